// File: rtl/trading_strategy_engine_if.sv
// Message-in / decision-out bus of the trading strategy engine.
// The engine takes the slave side; the parser/encoder pair takes the master side.
interface trading_strategy_engine_if #(
    parameter int SYM_W = 2
);
    logic             field_valid;
    logic             in_ready;
    logic [7:0]       msg_type;
    logic [SYM_W-1:0] symbol_id;
    logic [63:0]      order_id;
    logic [31:0]      price;
    logic [31:0]      volume;

    logic             decision_valid;
    logic             decision_ready;
    logic [7:0]       decision_type;
    logic [SYM_W-1:0] d_symbol;
    logic [63:0]      d_order_id;
    logic [31:0]      d_price;
    logic [31:0]      d_volume;

    modport master (
        output field_valid, msg_type, symbol_id, order_id, price, volume,
        input  in_ready,
        input  decision_valid, decision_type, d_symbol,
        input  d_order_id, d_price, d_volume,
        output decision_ready
    );

    modport slave (
        input  field_valid, msg_type, symbol_id, order_id, price, volume,
        output in_ready,
        output decision_valid, decision_type, d_symbol,
        output d_order_id, d_price, d_volume,
        input  decision_ready
    );
endinterface

// File: rtl/trading_strategy_engine.sv
// Per-symbol threshold strategy with position limit and cooldown.
// Decisions are queued in a small FIFO towards the order encoder.
module trading_strategy_engine #(
    parameter int NUM_SYMBOLS    = 4,
    parameter int SYM_W          = 2,
    parameter int BUY_THRESHOLD  = 20000,
    parameter int SELL_THRESHOLD = 30000,
    parameter int POS_LIMIT      = 1000,
    parameter int POS_W          = 40,
    parameter int COOLDOWN       = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    strategy_en,
    trading_strategy_engine_if.slave bus,
    input  logic [SYM_W-1:0]        pos_sel,
    output logic signed [POS_W-1:0] pos_out,
    output logic [31:0]             decision_count,
    output logic [31:0]             reject_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SYMS  = 2 ** SYM_W;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [SYM_W:0]        NUM_S  = (SYM_W + 1)'(NUM_SYMBOLS);
    localparam logic [31:0]           BUY_T  = 32'(BUY_THRESHOLD);
    localparam logic [31:0]           SELL_T = 32'(SELL_THRESHOLD);
    localparam logic signed [POS_W-1:0] LIM  = POS_W'(POS_LIMIT);
    localparam logic signed [POS_W-1:0] NLIM = -LIM;
    localparam logic [CD_W-1:0]       CD_RL  = CD_W'(COOLDOWN);
    localparam logic [AW:0]           DEPTH  = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]       dtype;
        logic [SYM_W-1:0] sym;
        logic [63:0]      oid;
        logic [31:0]      price;
        logic [31:0]      vol;
    } entry_t;

    entry_t mem [FIFO_DEPTH];
    entry_t head;
    entry_t last;
    entry_t shown;
    entry_t new_entry;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    logic signed [POS_W-1:0] pos [SYMS];
    logic [CD_W-1:0]         cd  [SYMS];

    logic                    trade;
    logic                    sym_ok;
    logic                    is_buy;
    logic                    is_sell;
    logic                    lim_ok;
    logic                    gate_ok;
    logic                    issue;
    logic                    reject;
    logic signed [POS_W-1:0] cur_pos;
    logic signed [POS_W-1:0] vol_ext;
    logic signed [POS_W-1:0] new_pos;
    logic [CD_W-1:0]         cur_cd;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign push  = issue;
    assign pop   = !empty && bus.decision_ready;
    assign head  = mem[rd_ptr[AW-1:0]];
    assign shown = empty ? last : head;

    assign bus.in_ready       = !full;
    assign bus.decision_valid = !empty;
    assign bus.decision_type  = shown.dtype;
    assign bus.d_symbol       = shown.sym;
    assign bus.d_order_id     = shown.oid;
    assign bus.d_price        = shown.price;
    assign bus.d_volume       = shown.vol;

    assign pos_out = pos[pos_sel];

    // Classify the incoming message and decide issue / reject.
    always_comb begin
        trade   = bus.field_valid && !full && strategy_en
                  && (bus.msg_type == 8'h54);
        sym_ok  = ({1'b0, bus.symbol_id} < NUM_S);
        cur_pos = pos[bus.symbol_id];
        cur_cd  = cd[bus.symbol_id];
        vol_ext = POS_W'(bus.volume);
        is_buy  = (bus.price < BUY_T);
        is_sell = !is_buy && (bus.price > SELL_T);
        new_pos = is_buy ? (cur_pos + vol_ext) : (cur_pos - vol_ext);
        lim_ok  = is_buy ? (new_pos <= LIM) : (new_pos >= NLIM);
        gate_ok = (cur_cd == '0) && lim_ok;
        issue   = trade && sym_ok && (bus.volume != '0)
                  && (is_buy || is_sell) && gate_ok;
        reject  = trade && (!sym_ok || (bus.volume == '0)
                  || ((is_buy || is_sell) && !gate_ok));
        new_entry.dtype = is_buy ? 8'h42 : 8'h53;
        new_entry.sym   = bus.symbol_id;
        new_entry.oid   = bus.order_id;
        new_entry.price = bus.price;
        new_entry.vol   = bus.volume;
    end

    // Decision FIFO; last popped entry keeps d_* stable once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= new_entry;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last   <= head;
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Positions, cooldown countdown/reload and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYMS; i++) begin
                pos[i] <= '0;
                cd[i]  <= '0;
            end
            decision_count <= '0;
            reject_count   <= '0;
        end else begin
            for (int i = 0; i < SYMS; i++) begin
                if (cd[i] != '0) cd[i] <= cd[i] - 1'b1;
            end
            if (issue) begin
                cd[bus.symbol_id]  <= CD_RL;
                pos[bus.symbol_id] <= new_pos;
                decision_count     <= decision_count + 32'd1;
            end
            if (reject) reject_count <= reject_count + 32'd1;
        end
    end
endmodule
